register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of each register and every data port.
REQ-002 Parameter: REG_COUNT, 32, number of registers; fixed at 32, matching the 5-bit address space.
REQ-003 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: write_enable  input  1  qualifies a write this cycle.
REQ-006 Port: write_address  input  5  destination register index.
REQ-007 Port: write_data  input  DATA_WIDTH  value to store.
REQ-008 Port: read_address_1  input  5  port 1 source register index.
REQ-009 Port: read_address_2  input  5  port 2 source register index.
REQ-010 Port: read_data_1  output  DATA_WIDTH  port 1 read value.
REQ-011 Port: read_data_2  output  DATA_WIDTH  port 2 read value.

Function
REQ-012 The block SHALL hold 32 registers of DATA_WIDTH bits, r0 to r31.
REQ-013 The block SHALL decode write_address internally into a 32-bit one-hot strobe.
REQ-014 Per-register load enable SHALL be write_enable AND its strobe bit; at most one register loads per cycle.
REQ-015 On a rising clock edge with reset high and a load enable set, that register SHALL take write_data; all other registers SHALL hold their value.
REQ-016 Write latency SHALL be one cycle: the new value is visible on the read ports after the rising edge that writes it.
REQ-017 r0 SHALL read as 0 at all times; writes to address 0 SHALL be discarded, with no storage change.
REQ-018 Reads SHALL be combinational: read_data_N equals register[read_address_N] within the same cycle.
REQ-019 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-020 With write_enable low, write_address and write_data SHALL have no effect.
REQ-021 X or Z on write_address SHALL NOT be masked by the block; it is the driving stage's responsibility to present a known address.

Reset
REQ-022 reset low SHALL asynchronously clear all registers to 0, without waiting for a clock edge.
REQ-023 While reset is low, read_data_1 and read_data_2 SHALL read 0 for every address.
REQ-024 reset low SHALL override a write in the same cycle; that write SHALL be lost.
REQ-025 After reset rises, the first rising clock edge SHALL accept a write normally.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-027 With REGFILE_BYPASS_EN defined, a read SHALL return write_data instead of the stored value when all of these hold: write_enable=1, read address equals write_address, address is nonzero, reset is high.
REQ-028 Without REGFILE_BYPASS_EN, reads SHALL return the stored (pre-edge) value in the same cycle as a write; there is no forwarding logic.
REQ-029 Forwarding SHALL never apply to address 0, in either configuration.

Verification
REQ-030 Reset: pulse reset low mid-cycle, no clock edge -> both read ports read 0 for all 32 addresses immediately.
REQ-031 Write/read: write 0xDEADBEEF to r5 -> next cycle read_address_1=5 gives 0xDEADBEEF; r4 and r6 still read 0.
REQ-032 r0: write 0xFFFFFFFF to address 0 -> both ports at address 0 read 0x00000000.
REQ-033 Sweep: write value i*0x01010101 to every ri, i=1..31, then read back each address on both ports -> all 31 values match.
REQ-034 Same-cycle read of address 7 while writing 0x12345678 to r7, r7 previously 0xA5A5A5A5:
  - with REGFILE_BYPASS_EN -> 0x12345678;
  - without REGFILE_BYPASS_EN -> 0xA5A5A5A5.
REQ-035 Reset versus write: reset low while writing 0x55 to r3 on the same edge -> r3 reads 0 after reset rises.

Source files
------------

// File: rtl/register_file.sv
// 32-entry, two-read/one-write register file with r0 hardwired to zero and asynchronous active-low clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [4:0]            write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [4:0]            read_address_1,
    input  logic [4:0]            read_address_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  strobe;
    logic [REG_COUNT-1:0]  load;

    always_comb begin
        strobe = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            strobe[i] = (write_address == i[4:0]);
        end
        load = strobe & {REG_COUNT{write_enable}};
    end

    // Entry 0 is cleared but never loaded; the read mux forces it to zero regardless.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (load[i]) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (addr != 5'd0) begin
            value = regs[addr];
`ifdef REGFILE_BYPASS_EN
            if (write_enable && reset && (addr == write_address)) begin
                value = write_data;
            end
`endif
        end
        return value;
    endfunction

    always_comb begin
        read_data_1 = read_port(read_address_1);
        read_data_2 = read_port(read_address_2);
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: per-cycle model comparison plus directed literal checks.
`timescale 1ns/1ps
module tb_register_file;

    logic        clock = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [4:0]  read_address_1;
    logic [4:0]  read_address_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;

    int compared   = 0;
    int mismatched = 0;
    bit run        = 1'b0;

    logic [31:0] model [32];

    always #5 clock = ~clock;

    register_file #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_data     (write_data),
        .read_address_1 (read_address_1),
        .read_address_2 (read_address_2),
        .read_data_1    (read_data_1),
        .read_data_2    (read_data_2)
    );

    // Architectural view: zero in reset or at r0, optional forwarding, else stored value.
    function automatic logic [31:0] expect_read(input logic [4:0] a);
        if (reset !== 1'b1 || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (write_enable && a == write_address) return write_data;
`endif
        return model[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge reset) begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end

    always @(posedge clock) begin
        if (reset === 1'b1 && write_enable && write_address != 5'd0)
            model[write_address] = write_data;
    end

    always @(negedge clock) begin
        if (run) begin
            check("cycle_port1", read_data_1, expect_read(read_address_1));
            check("cycle_port2", read_data_2, expect_read(read_address_2));
        end
    end

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        write_enable  = 1'b1;
        write_address = a;
        write_data    = d;
        @(posedge clock);
        #2;
        write_enable  = 1'b0;
    endtask

    task automatic read_both(input logic [4:0] a1, input logic [4:0] a2);
        read_address_1 = a1;
        read_address_2 = a2;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset          = 1'b0;
        write_enable   = 1'b0;
        write_address  = 5'd0;
        write_data     = 32'h0;
        read_address_1 = 5'd0;
        read_address_2 = 5'd0;
        #1;
        run = 1'b1;
        @(posedge clock);
        #2;
        read_both(5'd5, 5'd31);
        check("reset_state_p1", read_data_1, 32'h0);
        check("reset_state_p2", read_data_2, 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b1;

        // First edge after reset release accepts a write.
        write_reg(5'd9, 32'hCAFEF00D);
        read_both(5'd9, 5'd9);
        check("first_write_p1", read_data_1, 32'hCAFEF00D);
        check("first_write_p2", read_data_2, 32'hCAFEF00D);

        write_reg(5'd5, 32'hDEADBEEF);
        read_both(5'd5, 5'd4);
        check("r5_write", read_data_1, 32'hDEADBEEF);
        check("r4_untouched", read_data_2, 32'h0);
        read_both(5'd6, 5'd5);
        check("r6_untouched", read_data_1, 32'h0);
        check("r5_port2", read_data_2, 32'hDEADBEEF);

        // Write strobe low: address and data must be ignored.
        write_address = 5'd5;
        write_data    = 32'h13579BDF;
        @(posedge clock);
        #2;
        read_both(5'd5, 5'd5);
        check("we_low_hold", read_data_1, 32'hDEADBEEF);

        read_both(5'd0, 5'd0);
        write_enable  = 1'b1;
        write_address = 5'd0;
        write_data    = 32'hFFFFFFFF;
        #1;
        check("r0_same_cycle_p1", read_data_1, 32'h0);
        check("r0_same_cycle_p2", read_data_2, 32'h0);
        @(posedge clock);
        #2;
        write_enable = 1'b0;
        read_both(5'd0, 5'd0);
        check("r0_after_p1", read_data_1, 32'h0);
        check("r0_after_p2", read_data_2, 32'h0);

        for (int i = 1; i < 32; i++) write_reg(i[4:0], i * 32'h01010101);
        for (int i = 1; i < 32; i++) begin
            read_both(i[4:0], i[4:0]);
            check("sweep_p1", read_data_1, i * 32'h01010101);
            check("sweep_p2", read_data_2, i * 32'h01010101);
        end

        write_reg(5'd7, 32'hA5A5A5A5);
        read_address_1 = 5'd7;
        read_address_2 = 5'd7;
        write_enable   = 1'b1;
        write_address  = 5'd7;
        write_data     = 32'h12345678;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_r7", read_data_1, 32'h12345678);
`else
        check("same_cycle_r7", read_data_1, 32'hA5A5A5A5);
`endif
        @(posedge clock);
        #2;
        write_enable = 1'b0;
        read_both(5'd7, 5'd7);
        check("r7_after_edge", read_data_2, 32'h12345678);

        // Asynchronous clear mid-cycle with registers populated; no clock edge in between.
        @(posedge clock);
        #2;
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            read_address_1 = a[4:0];
            read_address_2 = 5'd31 - a[4:0];
            #0.05;
            check("async_reset_p1", read_data_1, 32'h0);
            check("async_reset_p2", read_data_2, 32'h0);
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
        read_both(5'd5, 5'd31);
        check("cleared_r5", read_data_1, 32'h0);
        check("cleared_r31", read_data_2, 32'h0);

        write_reg(5'd3, 32'h00000077);
        read_both(5'd3, 5'd3);
        check("r3_preload", read_data_1, 32'h00000077);
        write_enable  = 1'b1;
        write_address = 5'd3;
        write_data    = 32'h00000055;
        reset         = 1'b0;
        @(posedge clock);
        #2;
        write_enable = 1'b0;
        reset        = 1'b1;
        read_both(5'd3, 5'd3);
        check("reset_beats_write_p1", read_data_1, 32'h0);
        check("reset_beats_write_p2", read_data_2, 32'h0);

        @(posedge clock);
        #2;
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
